// File: rtl/shift_rx_pkg.sv
// Shared definitions for the serial-link receiver: FSM state encoding,
// frame length derivation and the lower bound on the idle timeout.
// Build option: SHIFT_RX_PARITY_EN adds a trailing even-parity bit to each frame.
package shift_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_EVAL  = 2'd2
    } rx_state_e;

    // Shorter timeouts cannot separate frames at the slowest legal SCK phase.
    localparam int MIN_IDLE_CYCLES = 4;

    // Number of serial bits in one well-formed frame.
    function automatic int frame_bits(input int width);
`ifdef SHIFT_RX_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/shift_rx_if.sv
// Parallel result bus of the serial-link receiver.
// The receiver drives it through the master modport; consumers use slave.
interface shift_rx_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             frame_err;
    logic             busy;

    modport master (
        output data_out,
        output data_valid,
        output frame_err,
        output busy
    );

    modport slave (
        input data_out,
        input data_valid,
        input frame_err,
        input busy
    );
endinterface

// File: rtl/shift_rx_sync.sv
// Brings the asynchronous shift clock and data into the clk domain.
// Both lines use the same synchronizer depth so SDI stays aligned to SCK;
// a third flop on SCK turns its rising edge into a one-cycle pulse.
module shift_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sck_in,
    input  logic sdi_in,
    output logic sdi_s,
    output logic sck_rise
);
    logic [1:0] sck_sync_q, sck_sync_d;
    logic [1:0] sdi_sync_q, sdi_sync_d;
    logic       sck_prev_q, sck_prev_d;

    // Next values: shift each line one stage deeper, remember last synced SCK.
    always_comb begin
        sck_sync_d = {sck_sync_q[0], sck_in};
        sdi_sync_d = {sdi_sync_q[0], sdi_in};
        sck_prev_d = sck_sync_q[1];
    end

    // Synchronizer and edge-detect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            sck_sync_q <= sck_sync_d;
            sdi_sync_q <= sdi_sync_d;
            sck_prev_q <= sck_prev_d;
        end
    end

    assign sdi_s    = sdi_sync_q[1];
    assign sck_rise = sck_sync_q[1] & ~sck_prev_q;

endmodule

// File: rtl/shift_receiver.sv
// Serial-link receiver: reassembles MSB-first frames from the two-wire
// shift-out port and presents them as parallel words with valid/error strobes.
// Build option: SHIFT_RX_PARITY_EN expects WIDTH data bits plus one even-parity bit.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | no frame in progress; first SCK edge starts one
//   ST_SHIFT | collecting bits; idle timer counts clk cycles since last edge
//   ST_EVAL  | one cycle: check length/parity, issue data_valid or frame_err
module shift_receiver
    import shift_rx_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int IDLE_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        sck_in,
    input  logic        sdi_in,
    shift_rx_if.master  rx
);
    localparam int FRAME_BITS = frame_bits(WIDTH);
    localparam int IDLE_EFF   = (IDLE_CYCLES < MIN_IDLE_CYCLES) ? MIN_IDLE_CYCLES : IDLE_CYCLES;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);
    localparam int TMR_W      = $clog2(IDLE_EFF);

    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_BITS + 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(IDLE_EFF - 1);

    logic sdi_s;
    logic sck_rise;

    shift_rx_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .sck_in   (sck_in),
        .sdi_in   (sdi_in),
        .sdi_s    (sdi_s),
        .sck_rise (sck_rise)
    );

    rx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [TMR_W-1:0] tmr_q,   tmr_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             valid_q, valid_d;
    logic             err_q,   err_d;
    logic             busy_q,  busy_d;

    logic [WIDTH-1:0] shreg_shift;
    logic             parity_ok;

`ifdef SHIFT_RX_PARITY_EN
    logic par_q, par_d;
    logic par_shift;

    // shreg and par_q form one chain; after WIDTH+1 edges par_q holds the parity bit.
    always_comb begin
        shreg_shift = {shreg_q[WIDTH-2:0], par_q};
        par_shift   = sdi_s;
        parity_ok   = ~(^shreg_q ^ par_q);
    end
`else
    // Without parity every correctly sized frame is accepted.
    always_comb begin
        shreg_shift = {shreg_q[WIDTH-2:0], sdi_s};
        parity_ok   = 1'b1;
    end
`endif

    // Frame FSM next-state, shift register, bit counter, idle timer and strobes.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
`ifdef SHIFT_RX_PARITY_EN
        par_d   = par_q;
`endif
        if (!ena) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            tmr_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sck_rise) begin
                        shreg_d = shreg_shift;
`ifdef SHIFT_RX_PARITY_EN
                        par_d   = par_shift;
`endif
                        cnt_d   = CNT_W'(1);
                        tmr_d   = '0;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sck_rise) begin
                        shreg_d = shreg_shift;
`ifdef SHIFT_RX_PARITY_EN
                        par_d   = par_shift;
`endif
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        tmr_d = '0;
                    end else if (tmr_q == TMR_LAST) begin
                        state_d = ST_EVAL;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                ST_EVAL: begin
                    // Any SCK edge landing here is deliberately dropped.
                    if (cnt_q == CNT_FRAME && parity_ok) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    cnt_d   = '0;
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    tmr_d   = '0;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Register all FSM state and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SHIFT_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
`ifdef SHIFT_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign rx.data_out   = data_q;
    assign rx.data_valid = valid_q;
    assign rx.frame_err  = err_q;
    assign rx.busy       = busy_q;

endmodule
